// File: rtl/universal_shift_register_pkg.sv
// Shared mode codes and serializer state encodings
// for the universal shift register datapath.
package universal_shift_register_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/dff_ar.sv
// 1-bit D flip-flop, asynchronous active-low reset.
// Ports: d (data), clk, rst_n, q (stored bit).
module dff_ar (
  input  logic d,
  input  logic clk,
  input  logic rst_n,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register (hold/shr/shl/load) plus a
// self-timed LSB-first serializer with busy/done status.
// Ports: clk, rst_n, mode, ser_in_r, ser_in_l, par_in,
//   start, par_out, ser_out_r, ser_out_l, busy, done.
module universal_shift_register
  import universal_shift_register_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  mode_e            op;
  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      busy  <= (state_n == ST_SHIFT);
      done  <= (state_n == ST_DONE);
    end
  end

  // op is the datapath command for this edge;
  // the FSM overrides mode outside IDLE.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op      = MODE_HOLD;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          op      = MODE_LOAD;
          cnt_n   = '0;
          state_n = ST_SHIFT;
        end else begin
          op = mode_e'(mode);
        end
      end
      ST_SHIFT: begin
        if (cnt == LAST) begin
          state_n = ST_DONE;
        end else begin
          op    = MODE_SHR;
          cnt_n = cnt + 1'b1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic hi, lo, d;

    // Neighbour taps; the end bits take the fill inputs.
    if (i == WIDTH - 1) begin : g_hi_fill
      assign hi = ser_in_r;
    end else begin : g_hi_tap
      assign hi = q[i+1];
    end

    if (i == 0) begin : g_lo_fill
      assign lo = ser_in_l;
    end else begin : g_lo_tap
      assign lo = q[i-1];
    end

    always_comb begin
      d = q[i];
      unique case (op)
        MODE_HOLD: d = q[i];
        MODE_SHR:  d = hi;
        MODE_SHL:  d = lo;
        MODE_LOAD: d = par_in[i];
        default:   d = q[i];
      endcase
    end

    dff_ar u_dff (
      .d     (d),
      .clk   (clk),
      .rst_n (rst_n),
      .q     (q[i])
    );
  end

  assign par_out   = q;
  assign ser_out_r = q[0];
  assign ser_out_l = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed scoreboard bench for universal_shift_register
// at WIDTH=8.
module tb_universal_shift_register;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       ser_in_r, ser_in_l, start;
  logic [7:0] par_in, par_out;
  logic       ser_out_r, ser_out_l, busy, done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  universal_shift_register #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .ser_in_r  (ser_in_r),
    .ser_in_l  (ser_in_l),
    .par_in    (par_in),
    .start     (start),
    .par_out   (par_out),
    .ser_out_r (ser_out_r),
    .ser_out_l (ser_out_l),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_q"},    par_out,           e.q);
      chk({e.tag, "_busy"}, {7'd0, busy},      {7'd0, e.busy});
      chk({e.tag, "_done"}, {7'd0, done},      {7'd0, e.done});
      chk({e.tag, "_sr"},   {7'd0, ser_out_r}, {7'd0, e.q[0]});
      chk({e.tag, "_sl"},   {7'd0, ser_out_l}, {7'd0, e.q[7]});
    end
  endtask

  task automatic step(input string tag,
                      input logic [7:0] q,
                      input logic b,
                      input logic d);
    exp_t e;
    e.tag  = tag;
    e.q    = q;
    e.busy = b;
    e.done = d;
    sb.push_back(e);
    tick();
  endtask

  task automatic idle_in();
    mode     = 2'b00;
    start    = 1'b0;
    ser_in_r = 1'b0;
    ser_in_l = 1'b0;
    par_in   = 8'h00;
  endtask

  initial begin
    logic [7:0] v;
    rst_n = 1'b0;
    idle_in();
    #12;
    chk("rst_q",    par_out,      8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_done", {7'd0, done}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: load then shift right with 1 fill
    mode = 2'b11; par_in = 8'hA5;
    step("t1_ld", 8'hA5, 0, 0);
    mode = 2'b01; ser_in_r = 1'b1;
    step("t1_r1", 8'hD2, 0, 0);
    step("t1_r2", 8'hE9, 0, 0);
    step("t1_r3", 8'hF4, 0, 0);

    // 2: load then shift left with 0 fill
    idle_in();
    mode = 2'b11; par_in = 8'h81;
    step("t2_ld", 8'h81, 0, 0);
    mode = 2'b10; ser_in_l = 1'b0;
    step("t2_l1", 8'h02, 0, 0);
    step("t2_l2", 8'h04, 0, 0);

    // 3: serialize 0xB4
    idle_in();
    start = 1'b1; par_in = 8'hB4;
    step("t3_c0", 8'hB4, 1, 0);
    start = 1'b0;
    for (int k = 1; k < 8; k++) begin
      v = 8'hB4 >> k;
      step($sformatf("t3_c%0d", k), v, 1, 0);
    end
    step("t3_done", 8'h01, 0, 1);
    step("t3_idle", 8'h01, 0, 0);

    // 4: serialize with hostile inputs during the run
    idle_in();
    start = 1'b1; par_in = 8'hB4;
    step("t4_c0", 8'hB4, 1, 0);
    mode = 2'b11; par_in = 8'hFF;
    for (int k = 1; k < 8; k++) begin
      start = k[0];
      v = 8'hB4 >> k;
      step($sformatf("t4_c%0d", k), v, 1, 0);
    end
    start = 1'b0;
    step("t4_done", 8'h01, 0, 1);
    start = 1'b1;
    step("t4_ign", 8'h01, 0, 0);
    idle_in();
    step("t4_idle", 8'h01, 0, 0);

    // 5: reset in cycle 3 of a run
    start = 1'b1; par_in = 8'hB4;
    step("t5_c0", 8'hB4, 1, 0);
    start = 1'b0;
    for (int k = 1; k < 4; k++) begin
      v = 8'hB4 >> k;
      step($sformatf("t5_c%0d", k), v, 1, 0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_q",    par_out,      8'h00);
    chk("t5_rst_busy", {7'd0, busy}, 8'h00);
    chk("t5_rst_done", {7'd0, done}, 8'h00);
    step("t5_hold0", 8'h00, 0, 0);
    step("t5_hold1", 8'h00, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1; par_in = 8'h5A;
    step("t5_n0", 8'h5A, 1, 0);
    start = 1'b0;
    for (int k = 1; k < 8; k++) begin
      v = 8'h5A >> k;
      step($sformatf("t5_n%0d", k), v, 1, 0);
    end
    step("t5_ndone", 8'h00, 0, 1);
    step("t5_nidle", 8'h00, 0, 0);

    // 6: load then hold
    idle_in();
    mode = 2'b11; par_in = 8'h3C;
    step("t6_ld", 8'h3C, 0, 0);
    mode = 2'b00; par_in = 8'hFF;
    for (int k = 0; k < 5; k++)
      step($sformatf("t6_h%0d", k), 8'h3C, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
